// File: rtl/alu_cmp_pkg.sv
// -----------------------------------------------------------------------------
// alu_cmp_pkg
//
// Shared definitions for the sequential magnitude comparator in the Mini ALU
// compare path.
//
// Contents:
//   cmp_state_t  - comparator FSM states (IDLE, SCAN)
//   CMP_LT/EQ/GT - one-hot result encoding, bit order {lt, eq, gt}
//   calc_ndig    - number of DIGIT-wide digits in a WIDTH-bit operand
//   calc_idx_w   - width of a digit index able to address calc_ndig digits
// -----------------------------------------------------------------------------
package alu_cmp_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } cmp_state_t;

  // One-hot result vector, packed as {lt, eq, gt}.
  localparam logic [2:0] CMP_LT = 3'b100;
  localparam logic [2:0] CMP_EQ = 3'b010;
  localparam logic [2:0] CMP_GT = 3'b001;

  function automatic int calc_ndig(input int width, input int digit);
    return width / digit;
  endfunction

  // A single-digit operand still needs a 1-bit index register.
  function automatic int calc_idx_w(input int ndig);
    return (ndig > 1) ? $clog2(ndig) : 1;
  endfunction

endpackage

// File: rtl/seq_magnitude_comparator_digit.sv
// -----------------------------------------------------------------------------
// cmp_digit
//
// Combinational unsigned comparator for one DIGIT-wide slice of the operands.
//
// Ports:
//   a_i      [DIGIT-1:0] in   slice of operand A
//   b_i      [DIGIT-1:0] in   slice of operand B
//   diff_o               out  slices differ
//   a_lt_b_o             out  slice A < slice B (unsigned)
// -----------------------------------------------------------------------------
module cmp_digit #(
  parameter int DIGIT = 2
) (
  input  logic [DIGIT-1:0] a_i,
  input  logic [DIGIT-1:0] b_i,
  output logic             diff_o,
  output logic             a_lt_b_o
);

  assign diff_o   = (a_i != b_i);
  assign a_lt_b_o = (a_i < b_i);

endmodule

// File: rtl/seq_magnitude_comparator.sv
// -----------------------------------------------------------------------------
// seq_magnitude_comparator
//
// Multi-cycle magnitude comparator. Operands are captured on an accepted
// start, then compared MSB-first one DIGIT-wide digit per clock; the scan
// stops at the first differing digit. Flags and the per-bit less-than vector
// are registered and held until the next accepted start.
//
// Parameters:
//   WIDTH  operand width (>= 2, integer multiple of DIGIT)
//   DIGIT  bits examined per SCAN cycle
//
// Ports:
//   clk          in   clock, rising edge
//   rst          in   asynchronous, active-high reset
//   start        in   compare request, sampled only in IDLE
//   signed_mode  in   two's-complement compare (only with SEQ_CMP_SIGNED_EN)
//   in1 [W-1:0]  in   operand A, captured with start
//   in2 [W-1:0]  in   operand B, captured with start
//   busy         out  high while scanning
//   done         out  one-cycle pulse when lt/eq/gt become valid
//   lt/eq/gt     out  A < B / A == B / A > B
//   y   [W-1:0]  out  ~in1 & in2 of the captured raw operands
//
// Build option: define SEQ_CMP_SIGNED_EN to add the signed_mode input.
// -----------------------------------------------------------------------------
module seq_magnitude_comparator
  import alu_cmp_pkg::*;
#(
  parameter int WIDTH = 6,
  parameter int DIGIT = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
`ifdef SEQ_CMP_SIGNED_EN
  input  logic             signed_mode,
`endif
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  output logic             busy,
  output logic             done,
  output logic             lt,
  output logic             eq,
  output logic             gt,
  output logic [WIDTH-1:0] y
);

  localparam int NDIG = calc_ndig(WIDTH, DIGIT);
  localparam int IDXW = calc_idx_w(NDIG);
  localparam logic [IDXW-1:0] IDX_TOP = IDXW'(NDIG - 1);

  cmp_state_t       state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] y_q;
  logic [IDXW-1:0]  idx_q;
  logic [2:0]       res_q;
  logic             busy_q;
  logic             done_q;

  logic [WIDTH-1:0] a_d;
  logic [WIDTH-1:0] b_d;
  logic [WIDTH-1:0] y_d;
  logic [WIDTH-1:0] flip_d;

  // Signed compare: flipping both MSBs maps two's-complement order onto
  // unsigned order, so the scan datapath stays purely unsigned.
`ifdef SEQ_CMP_SIGNED_EN
  localparam logic [WIDTH-1:0] MSB_MASK = {1'b1, {(WIDTH-1){1'b0}}};
  assign flip_d = signed_mode ? MSB_MASK : '0;
`else
  assign flip_d = '0;
`endif

  assign a_d = in1 ^ flip_d;
  assign b_d = in2 ^ flip_d;

  // y always reflects the raw operands, independent of signed correction.
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_ybit
    assign y_d[gi] = ~in1[gi] & in2[gi];
  end

  // Split the captured operands into digits; the scan selects one by idx_q.
  logic [DIGIT-1:0] a_dig [NDIG];
  logic [DIGIT-1:0] b_dig [NDIG];

  for (genvar gi = 0; gi < NDIG; gi++) begin : g_digit
    assign a_dig[gi] = a_q[gi*DIGIT +: DIGIT];
    assign b_dig[gi] = b_q[gi*DIGIT +: DIGIT];
  end

  logic dig_diff;
  logic dig_lt;

  cmp_digit #(
    .DIGIT (DIGIT)
  ) u_cmp_digit (
    .a_i      (a_dig[idx_q]),
    .b_i      (b_dig[idx_q]),
    .diff_o   (dig_diff),
    .a_lt_b_o (dig_lt)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      y_q     <= '0;
      idx_q   <= '0;
      res_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      // done is a single-cycle pulse unless a decision is made below.
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            a_q     <= a_d;
            b_q     <= b_d;
            y_q     <= y_d;
            idx_q   <= IDX_TOP;
            res_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= SCAN;
          end
        end
        SCAN: begin
          // start is deliberately ignored here.
          if (dig_diff) begin
            res_q   <= dig_lt ? CMP_LT : CMP_GT;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else if (idx_q == '0) begin
            res_q   <= CMP_EQ;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            idx_q <= idx_q - 1'b1;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign lt   = res_q[2];
  assign eq   = res_q[1];
  assign gt   = res_q[0];
  assign y    = y_q;

endmodule

// File: tb/tb_seq_magnitude_comparator.sv
// -----------------------------------------------------------------------------
// tb_seq_magnitude_comparator
//
// Directed bench for seq_magnitude_comparator (WIDTH=6, DIGIT=2). Expected
// values are hand-computed per vector. Cycle numbering: cycle 1 is the first
// cycle after the edge that accepts start.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_seq_magnitude_comparator;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [5:0] in1 = '0;
  logic [5:0] in2 = '0;
  logic       busy, done, lt, eq, gt;
  logic [5:0] y;
`ifdef SEQ_CMP_SIGNED_EN
  logic       signed_mode = 1'b0;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  seq_magnitude_comparator #(
    .WIDTH (6),
    .DIGIT (2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
`ifdef SEQ_CMP_SIGNED_EN
    .signed_mode (signed_mode),
`endif
    .in1         (in1),
    .in2         (in2),
    .busy        (busy),
    .done        (done),
    .lt          (lt),
    .eq          (eq),
    .gt          (gt),
    .y           (y)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Drive a request at the falling edge, let the next rising edge accept it.
  task automatic start_cmp(input logic [5:0] a, input logic [5:0] b);
    @(negedge clk);
    in1   = a;
    in2   = b;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Called in cycle 1; returns the cycle in which done is seen and the number
  // of busy cycles before it. pulse_at > 0 raises start for one cycle then.
  task automatic wait_done(input int pulse_at, output int cyc, output int busy_cyc);
    cyc = 1;
    busy_cyc = 0;
    while (done !== 1'b1 && cyc < 20) begin
      if (busy === 1'b1) busy_cyc++;
      if (cyc == pulse_at) begin
        start = 1'b1;
        in1   = 6'h3F;
        in2   = 6'h00;
      end
      @(posedge clk);
      #1;
      start = 1'b0;
      cyc++;
    end
    if (done !== 1'b1) check_val("done_timeout", 32'(done), 32'd1);
  endtask

  task automatic check_flags(input string tag, input logic [2:0] exp_flags, input logic [5:0] exp_y);
    check_val({tag, "_flags"}, 32'({lt, eq, gt}), 32'(exp_flags));
    check_val({tag, "_y"}, 32'(y), 32'(exp_y));
  endtask

  int cyc, bcyc;

  initial begin
    // Reset state
    #1;
    check_val("rst_busy", 32'(busy), 32'd0);
    check_val("rst_done", 32'(done), 32'd0);
    check_flags("rst", 3'b000, 6'h00);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // T1: 5 vs 9 -> second digit decides, done in cycle 3, lt
    start_cmp(6'd5, 6'd9);
    wait_done(0, cyc, bcyc);
    check_val("t1_latency", 32'(cyc), 32'd3);
    check_flags("t1", 3'b100, 6'b001000);
    @(posedge clk); #1;
    check_val("t1_done_pulse", 32'(done), 32'd0);
    check_val("t1_hold_lt", 32'(lt), 32'd1);
    $display("T1 5 vs 9: latency=%0d lt=%0b eq=%0b gt=%0b y=%b", cyc, lt, eq, gt, y);

    // T2: equal operands -> full scan, eq
    start_cmp(6'h2A, 6'h2A);
    wait_done(0, cyc, bcyc);
    check_val("t2_latency", 32'(cyc), 32'd4);
    check_val("t2_busy_cycles", 32'(bcyc), 32'd3);
    check_val("t2_busy_at_done", 32'(busy), 32'd0);
    check_flags("t2", 3'b010, 6'h00);
    $display("T2 2A vs 2A: latency=%0d busy_cycles=%0d eq=%0b", cyc, bcyc, eq);

    // T3a: top digit decides -> done in cycle 2, gt
    start_cmp(6'h30, 6'h0F);
    wait_done(0, cyc, bcyc);
    check_val("t3a_latency", 32'(cyc), 32'd2);
    check_flags("t3a", 3'b001, 6'h0F);
    $display("T3a 30 vs 0F: latency=%0d gt=%0b y=%b", cyc, gt, y);

    // T3b: start pulsed during SCAN of a 3-digit compare must be ignored
    start_cmp(6'h2A, 6'h2B);
    wait_done(1, cyc, bcyc);
    check_val("t3b_latency", 32'(cyc), 32'd4);
    check_flags("t3b", 3'b100, 6'h01);
    @(posedge clk); #1;
    check_val("t3b_no_restart", 32'(busy), 32'd0);
    $display("T3b 2A vs 2B with ignored start: latency=%0d lt=%0b y=%b", cyc, lt, y);

    // T4: back-to-back, start held high through the done cycle
    @(negedge clk);
    in1   = 6'h10;
    in2   = 6'h20;
    start = 1'b1;
    @(posedge clk); #1;           // cycle 1 of first compare
    in1   = 6'h01;
    in2   = 6'h02;
    @(posedge clk); #1;           // cycle 2: done of first compare
    check_val("t4a_done", 32'(done), 32'd1);
    check_flags("t4a", 3'b100, 6'b100000);
    @(posedge clk); #1;           // cycle 1 of second compare
    start = 1'b0;
    check_val("t4b_accepted", 32'(busy), 32'd1);
    check_val("t4b_flags_cleared", 32'({lt, eq, gt}), 32'd0);
    check_val("t4b_y_early", 32'(y), 32'h02);
    wait_done(0, cyc, bcyc);
    check_val("t4b_latency", 32'(cyc), 32'd4);
    check_flags("t4b", 3'b100, 6'h02);
    $display("T4 back-to-back 1 vs 2: latency=%0d lt=%0b", cyc, lt);

    // T5: reset in the second SCAN cycle aborts with no done
    start_cmp(6'h2A, 6'h2A);
    @(posedge clk); #1;           // cycle 2, still scanning
    rst = 1'b1;
    #1;
    check_val("t5_busy", 32'(busy), 32'd0);
    check_val("t5_done", 32'(done), 32'd0);
    check_flags("t5", 3'b000, 6'h00);
    bcyc = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (done === 1'b1) bcyc++;
    end
    check_val("t5_no_done", 32'(bcyc), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    start_cmp(6'h3F, 6'h01);
    wait_done(0, cyc, bcyc);
    check_val("t5_latency", 32'(cyc), 32'd2);
    check_flags("t5_after", 3'b001, 6'h00);
    $display("T5 reset abort then 3F vs 01: latency=%0d gt=%0b", cyc, gt);

`ifdef SEQ_CMP_SIGNED_EN
    // T6: signed mode, -1 vs 1
    signed_mode = 1'b1;
    start_cmp(6'h3F, 6'h01);
    signed_mode = 1'b0;
    wait_done(0, cyc, bcyc);
    check_flags("t6_signed", 3'b100, 6'h00);
    $display("T6 signed -1 vs 1: lt=%0b", lt);
    start_cmp(6'h3F, 6'h01);
    wait_done(0, cyc, bcyc);
    check_flags("t6_unsigned", 3'b001, 6'h00);
    $display("T6 unsigned 3F vs 01: gt=%0b", gt);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/seq_magnitude_comparator.md
Name: seq_magnitude_comparator

Overview:
Multi-cycle, parametrised magnitude comparator for the Mini ALU. It compares two WIDTH-bit operands MSB-first, DIGIT bits per clock, and stops early at the first differing digit. It returns registered lt/eq/gt flags plus the per-bit less-than vector (~in1 & in2) under a start/done handshake. It replaces the fixed 6-bit combinational bitwise comparator in the ALU compare path.

Parameters:
WIDTH, 6, operand width in bits; must be at least 2.
DIGIT, 2, bits examined per SCAN cycle; WIDTH must be an integer multiple of DIGIT.
NDIG, WIDTH/DIGIT, number of digits (derived localparam, not overridable).

Ports:
clk  in  1  system clock; all state updates on its rising edge
rst  in  1  asynchronous, active-high reset
start  in  1  request a compare; sampled only in IDLE
in1  in  WIDTH  operand A; sampled in the cycle start is accepted
in2  in  WIDTH  operand B; sampled in the cycle start is accepted
busy  out  1  high while in SCAN
done  out  1  one-cycle pulse; lt/eq/gt are valid from this cycle on
lt  out  1  A < B
eq  out  1  A == B
gt  out  1  A > B
y  out  WIDTH  per-bit less-than: y[i] = ~in1[i] & in2[i], for the captured operands

Behaviour:
- Clocking and reset (already decided): one clock, clk; reset rst is asynchronous and active-high.
- Reset values: state=IDLE, busy=0, done=0, lt=0, eq=0, gt=0, y=0, operand registers=0, digit index=0.
- Reset asserted mid-SCAN aborts the compare immediately. No done pulse is produced for the aborted request.
- FSM states: IDLE, SCAN.
- IDLE, start=1:
  - capture in1 and in2 into internal registers;
  - register y;
  - load digit index with NDIG-1;
  - clear lt/eq/gt;
  - go to SCAN.
  - The start cycle is the acceptance cycle; no separate ready signal exists.
- SCAN, each cycle: compare slice [idx*DIGIT +: DIGIT] of A against the same slice of B.
  - Slices differ: set lt or gt from the unsigned slice comparison, pulse done next cycle, go to IDLE.
  - Slices equal and idx==0: set eq=1, pulse done next cycle, go to IDLE.
  - Slices equal and idx>0: decrement idx, stay in SCAN.
- Latency:
  - start accepted at edge 0; the deciding digit is the k-th digit, 1 ≤ k ≤ NDIG.
  - Flags are registered and done=1 in cycle k+1 after acceptance.
  - Best case 2 cycles; worst case NDIG+1 cycles.
- busy=1 exactly during SCAN cycles. done is never high while busy is high.
- start while busy is ignored: not queued, and operands are not resampled.
- start in the same cycle done is high is accepted, giving back-to-back operation. The flags then clear on the next edge.
- lt/eq/gt and y hold their values until the next accepted start. Exactly one of lt/eq/gt is 1 after any done.
- y is registered at capture, so it is valid from the first SCAN cycle onward.

Optional Feature:
Macro: SEQ_CMP_SIGNED_EN.
- Defined:
  - adds input port signed_mode (1 bit), sampled together with start;
  - when signed_mode=1, the operand MSBs are inverted at capture, so two's-complement order maps onto unsigned order;
  - y is always computed from the raw, uncorrected operands.
- Undefined: the port is absent and all compares are unsigned. Behaviour is otherwise identical.

Decomposition:
- Shared package alu_cmp_pkg holds:
  - FSM state enum cmp_state_t {IDLE, SCAN};
  - result encoding constants CMP_LT, CMP_EQ, CMP_GT;
  - a NDIG computation helper function.
- One natural sub-module: cmp_digit. It is a combinational DIGIT-wide slice comparator with outputs diff and a_lt_b. It is instantiated once and fed by a mux on idx.
- The existing single-bit comparator cell may be reused inside the generate loop that produces y.

Test Plan:
1. WIDTH=6, DIGIT=2: in1=5, in2=9, start -> first digit equal, second digit differs; done 3 cycles after acceptance; lt=1, eq=0, gt=0, y=6'b001000.
2. in1=in2=6'h2A -> done after NDIG+1=4 cycles; eq=1; y=0; busy high for exactly 3 cycles.
3. in1=6'h30, in2=6'h0F -> top digit differs; done at 2 cycles; gt=1. Pulse start again during SCAN of a longer compare -> ignored, result unchanged.
4. Back-to-back: start held high through the done cycle with new operands 1 vs 2 -> second compare accepted in the done cycle; second done gives lt=1.
5. Assert rst in the second SCAN cycle -> all outputs 0 immediately; no done; next start compares correctly.
6. SEQ_CMP_SIGNED_EN defined, signed_mode=1: in1=6'h3F (-1), in2=6'h01 -> lt=1. Same operands with signed_mode=0 -> gt=1.
